div512_r2_rca: RTL and testbench
================================

// Module: div512_r2_rca
// PURPOSE
//  Iterative radix-2 restoring divider, the inverse datapath of the 512-bit MAC.
//  Divides a 2N-bit dividend (a MAC product/accumulator) by an N-bit divisor, giving an N-bit quotient and remainder.
//  It is the reverse path used to check MAC results and to normalise accumulators.
//  It uses a start/done handshake, processes one quotient bit per enabled cycle, and does its trial subtraction with the ripple-carry adder.
// PARAMETERS
//  N      256   divisor/quotient/remainder width; dividend is 2N
//  CNT_W  8     iteration counter width; must satisfy 2^CNT_W >= N
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    reset, synchronous, active-low (sampled on the clk rising edge)
//  en         in   1    clock enable; when low all state holds
//  start      in   1    request; sampled when en=1 in IDLE or DONE
//  dividend   in   2N   captured on the accepted start
//  divisor    in   N    captured on the accepted start
//  busy       out  1    1 while in RUN
//  done       out  1    1 for exactly one enabled cycle when the result is valid
//  quotient   out  N    result; held until the next accepted start
//  remainder  out  N    result; held until the next accepted start
//  div_by_zero out 1    exception flag; valid when done=1, held with the result
//  overflow   out  1    exception flag; valid when done=1, held with the result
// BEHAVIOUR
//  Reset: rst_n=0 at an edge sets the following on that edge, regardless of en:
//   - state=IDLE, counter=0;
//   - busy=done=div_by_zero=overflow=0;
//   - quotient=remainder=0.
//  Reset mid-RUN aborts the operation; no done is produced.
//  States (2-bit): IDLE, RUN, DONE.
//  IDLE/DONE with en=1 and start=1 (start accepted at edge t0):
//   - operands are latched and both flags are cleared;
//   - divisor==0: go to DONE; quotient={N{1}}, remainder=dividend[N-1:0], div_by_zero=1;
//   - else dividend[2N-1:N] >= divisor: go to DONE; quotient={N{1}}, remainder=0, overflow=1;
//   - else go to RUN; partial remainder R(N+1 b)=dividend[2N-1:N]; Q shift reg=dividend[N-1:0]; counter=0.
//  RUN, once per enabled edge:
//   - T = {R[N-1:0], Q[N-1]} - {1'b0, divisor}, computed in N+1 bits via the RCA with cin=1 and ~y;
//   - borrow-free (RCA cout=1): R<=T and Q<={Q[N-2:0],1}; otherwise R<={R[N-1:0],Q[N-1]} and Q<={Q[N-2:0],0};
//   - counter increments; the edge with counter==N-1 moves to DONE and loads quotient=Q, remainder=R[N-1:0].
//  Invariant: R < divisor before every step, so no bits are lost in the N+1-bit R.
//  Latency, measured from the accept edge t0 and counting enabled edges only:
//   - normal operation: done visible after edge t0+N;
//   - exception: done visible after edge t0.
//  DONE:
//   - done=1; the next enabled edge returns to IDLE, or starts a new operation if start=1 (back-to-back);
//   - with en=0, done stays 1 until an enabled edge.
//  start while busy=1 is ignored; operands are not re-latched.
//  en=0 in RUN freezes R, Q and counter; the result is identical to an uninterrupted run.
//  busy and done are never both 1. Outputs change only on enabled edges or on reset.
// STRUCTURE
//  Shared include div_mac_defs.vh holds:
//   - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//   - the default widths N_DEF=256 and CNT_W_DEF=8.
//  One sub-module: the existing RCA, WIDTH=N+1, used as the trial subtractor (x=shifted R, y=~divisor, cin=1).
//  FSM, counter and R/Q registers live in this module; no other children.
// TESTING
//  1. dividend=1000, divisor=7 -> quotient=142, remainder=6, flags 0; done exactly 256 enabled edges after start.
//  2. divisor=0, dividend=5 -> div_by_zero=1, quotient=all-ones, remainder=5; done on the cycle after the accept edge; busy never 1.
//  3. Two cases on the overflow boundary:
//   - dividend=2^256, divisor=1 -> overflow=1, quotient=all-ones, remainder=0;
//   - dividend=(2^256-1)^2, divisor=2^256-1 -> quotient=2^256-1, remainder=0, overflow=0.
//  4. en low for 10 cycles at iteration 100, plus start pulsed while busy -> done 10 cycles late, result unchanged, second start ignored.
//  5. rst_n low for one edge at iteration 100 -> all outputs 0 after that edge, no done; new start 123456789/1000 -> quotient 123456, remainder 789.
//  6. Round-trip with MAC512 over 50 random A,B!=0, dividend=A*B+C with C<B -> quotient=A, remainder=C; back-to-back starts from DONE.

Source files
------------

// File: rtl/div512_r2_rca_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div512_r2_rca_pkg
// Purpose  : Shared definitions for the radix-2 restoring divider: FSM
//            state encodings and default datapath widths.
// Revision : 1.0 - initial release
// ============================================================================
package div512_r2_rca_pkg;

    // Default widths: divisor/quotient/remainder are N_DEF bits, the
    // dividend is 2*N_DEF bits, and the iteration counter must reach N_DEF-1.
    localparam int N_DEF     = 256;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : div512_r2_rca_pkg
`default_nettype wire

// File: rtl/div512_r2_rca_rca.sv
`default_nettype none
// ============================================================================
// Module   : div512_r2_rca_rca
// Purpose  : Parameterised ripple-carry adder, sum = x + y + cin.
//            Used by the divider as its trial subtractor (y = ~divisor,
//            cin = 1), where cout = 1 means the subtraction did not borrow.
// Ports    : x, y  [WIDTH-1:0] in   addends
//            cin              in   carry in
//            sum   [WIDTH-1:0] out  sum bits
//            cout             out  carry out of the MSB
// Revision : 1.0 - initial release
// ============================================================================
module div512_r2_rca_rca #(
    parameter int WIDTH = 257
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The carry is carried bit to bit through a procedural variable so the
    // chain is a true ripple without a self-referencing carry vector.
    always_comb begin
        logic w_c;
        w_c  = cin;
        sum  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = x[i] ^ y[i] ^ w_c;
            w_c    = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
        end
        cout = w_c;
    end

endmodule : div512_r2_rca_rca
`default_nettype wire

// File: rtl/div512_r2_rca.sv
`default_nettype none
// ============================================================================
// Module   : div512_r2_rca
// Purpose  : Iterative radix-2 restoring divider. Divides a 2N-bit dividend
//            by an N-bit divisor, one quotient bit per enabled cycle, using
//            a ripple-carry adder for the trial subtraction.
// Ports    : clk, rst_n (sync, active-low), en (clock enable)
//            start, dividend[2N-1:0], divisor[N-1:0]   request + operands
//            busy, done                                status
//            quotient[N-1:0], remainder[N-1:0]         result
//            div_by_zero, overflow                     exception flags
// Revision : 1.0 - initial release
// ============================================================================
module div512_r2_rca
    import div512_r2_rca_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_rem;   // partial remainder, always < divisor
    logic [N-1:0]     r_q;     // dividend low half shifting out, quotient in
    logic [N-1:0]     r_dvs;

    logic [N:0]       w_x;
    logic [N:0]       w_y;
    logic [N:0]       w_t;
    logic             w_cout;
    logic [N:0]       w_rem_next;
    logic [N-1:0]     w_q_next;
    logic             w_unused_rem_msb;

    // Shifted partial remainder is N+1 bits; subtract the zero-extended
    // divisor as x + ~y + 1. A carry out means no borrow, i.e. x >= divisor.
    assign w_x = {r_rem, r_q[N-1]};
    assign w_y = ~{1'b0, r_dvs};

    div512_r2_rca_rca #(
        .WIDTH (N + 1)
    ) u_rca (
        .x    (w_x),
        .y    (w_y),
        .cin  (1'b1),
        .sum  (w_t),
        .cout (w_cout)
    );

    assign w_rem_next = w_cout ? w_t : w_x;
    assign w_q_next   = {r_q[N-2:0], w_cout};
    // The restored/subtracted remainder is always below the divisor, so its
    // MSB is zero and only the low N bits need storing.
    assign w_unused_rem_msb = w_rem_next[N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_dvs       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (en) begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        r_dvs       <= divisor;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (divisor == '0) begin
                            r_state     <= ST_DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                        end else if (dividend[2*N-1:N] >= divisor) begin
                            // Quotient would not fit in N bits.
                            r_state   <= ST_DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= '0;
                            overflow  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            busy    <= 1'b1;
                            r_rem   <= dividend[2*N-1:N];
                            r_q     <= dividend[N-1:0];
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem_next[N-1:0];
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state   <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= w_q_next;
                        remainder <= w_rem_next[N-1:0];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule : div512_r2_rca
`default_nettype wire

// File: tb/tb_div512_r2_rca.sv
`default_nettype none
// ============================================================================
// Module   : tb_div512_r2_rca
// Purpose  : Self-checking bench for div512_r2_rca. A driver issues requests
//            and pushes the reference result into a queue; a monitor pops and
//            compares whenever the divider presents done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div512_r2_rca;

    localparam int N = 256;
    localparam int W = 2 * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          start;
    logic [W-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [N-1:0]  quotient;
    logic [N-1:0]  remainder;
    logic          div_by_zero;
    logic          overflow;

    always #5 clk = ~clk;

    div512_r2_rca #(
        .N     (N),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;     // enabled edges from accept to done
        int           raw;     // all edges from accept to done
        longint       acc_en;
        longint       acc_cyc;
        int           id;
    } exp_t;

    exp_t   exp_q[$];
    int     total = 0;
    int     bad   = 0;
    longint cyc      = 0;
    longint en_edges = 0;
    int     stall    = 0;
    int     next_id  = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en) en_edges <= en_edges + 1;
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain wide division; the quotient must fit in N bits.
    task automatic model(input logic [W-1:0] dvd, input logic [N-1:0] dvs, output exp_t e);
        logic [W-1:0] qw;
        logic [W-1:0] rw;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.q   = '0;
        e.r   = '0;
        e.lat = 0;
        if (dvs == '0) begin
            e.q   = '1;
            e.r   = dvd[N-1:0];
            e.dbz = 1'b1;
        end else begin
            qw = dvd / W'(dvs);
            rw = dvd % W'(dvs);
            if (qw[W-1:N] != '0) begin
                e.q   = '1;
                e.ovf = 1'b1;
            end else begin
                e.q   = qw[N-1:0];
                e.r   = rw[N-1:0];
                e.lat = N;
            end
        end
    endtask

    function automatic logic [N-1:0] rnd256();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [W-1:0] dvd, input logic [N-1:0] dvs);
        exp_t e;
        int   guard = 0;
        while (busy === 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            total++;
            bad++;
            $display("FAIL issue_wait_timeout: busy still %b", busy);
            return;
        end
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        model(dvd, dvs, e);
        @(posedge clk);
        #1;
        start     = 1'b0;
        e.acc_en  = en_edges;
        e.acc_cyc = cyc;
        e.raw     = (e.lat != 0) ? e.lat + stall : 0;
        e.id      = next_id++;
        exp_q.push_back(e);
        @(negedge clk);
        chk_int("busy_after_accept", longint'(busy), (e.lat != 0) ? 1 : 0);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: one pop per enabled cycle in which done is presented.
    longint last_pop = -1;
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && done && en_edges != last_pop) begin
            last_pop = en_edges;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: q=%h r=%h", quotient, remainder);
            end else begin
                e = exp_q.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk_int("div_by_zero", longint'(div_by_zero), longint'(e.dbz));
                chk_int("overflow", longint'(overflow), longint'(e.ovf));
                chk_int("latency_en_edges", en_edges - e.acc_en, longint'(e.lat));
                chk_int("latency_cycles", cyc - e.acc_cyc, longint'(e.raw));
                chk_int("busy_with_done", longint'(busy), 0);
                if (bad != 0 && e.id < 8) $display("  (op id %0d)", e.id);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_quotient"}, quotient, '0);
        chk({tag, "_remainder"}, remainder, '0);
        chk_int({tag, "_busy"}, longint'(busy), 0);
        chk_int({tag, "_done"}, longint'(done), 0);
        chk_int({tag, "_dbz"}, longint'(div_by_zero), 0);
        chk_int({tag, "_ovf"}, longint'(overflow), 0);
    endtask

    initial begin : stim
        logic [W-1:0] tmp;
        logic [W-1:0] ones;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] c;

        rst_n    = 1'b0;
        en       = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic division with exact latency.
        issue(W'(1000), N'(7));
        drain();

        // Divide by zero.
        issue(W'(5), N'(0));
        drain();

        // Overflow boundary on either side.
        tmp    = '0;
        tmp[N] = 1'b1;
        issue(tmp, N'(1));
        ones = {{N{1'b0}}, {N{1'b1}}};
        tmp  = ones * ones;
        issue(tmp, {N{1'b1}});
        drain();

        // Enable stall mid-run plus a start pulse while busy.
        stall = 10;
        a = rnd256();
        b = rnd256() | (N'(1) << (N - 1));
        issue(W'(a) * W'(b) + W'(N'(12345)), b);
        repeat (99) @(negedge clk);
        dividend = {W{1'b1}};
        divisor  = N'(3);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en    = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        drain();
        stall = 0;

        // Reset in the middle of a run aborts it.
        issue(W'(a) * W'(b), b);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        chk_all_zero("midrun_reset");
        repeat (300) @(negedge clk);
        issue(W'(123456789), N'(1000));
        drain();

        // Round trip A*B+C with C<B, back-to-back from DONE.
        for (int i = 0; i < 50; i++) begin
            a = rnd256();
            if (a == '0) a = N'(1);
            b = rnd256() >> $urandom_range(0, 255);
            if (b == '0) b = N'(1);
            c = rnd256() % b;
            issue(W'(a) * W'(b) + W'(c), b);
        end
        drain();

        // Unconstrained operands: mostly overflow, some divide by zero.
        for (int i = 0; i < 12; i++) begin
            tmp = {rnd256(), rnd256()};
            b   = (i % 4 == 0) ? N'(0) : rnd256();
            issue(tmp, b);
        end
        drain();

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div512_r2_rca
`default_nettype wire
